// File: rtl/mul4_seq_ctrl_pkg.sv
// Shared constants and state encoding for the sequential 4x4 shift-add multiplier.
package mul4_seq_ctrl_pkg;

  localparam int unsigned OPW       = 4;
  localparam int unsigned PW        = 8;
  localparam int unsigned MUL_STEPS = 4;
  localparam int unsigned CNTW      = $clog2(MUL_STEPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul4_seq_ctrl_if.sv
// Start/busy/done handshake and operand/product bus between wrapper and multiplier core.
interface mul4_seq_ctrl_if;
  import mul4_seq_ctrl_pkg::*;

  logic           start;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic           busy;
  logic           done;
  logic [PW-1:0]  product;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/mul4_seq_ctrl_rca4.sv
// 4-bit ripple-carry adder used as the shared datapath adder of the multiplier.
module rca4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 4; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_c[4];

endmodule

// File: rtl/mul4_seq_ctrl.sv
// Sequential 4x4 unsigned shift-add multiplier: one adder time-shared over four RUN steps,
// start/busy/done handshake, all outputs decoded from registers.
module mul4_seq_ctrl
  import mul4_seq_ctrl_pkg::*;
#(
  parameter bit HOLD_PRODUCT = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mul4_seq_ctrl_if.slave io_bus
);

  state_e          r_state;
  state_e          w_state_d;
  logic [OPW-1:0]  r_mcand;
  logic [OPW-1:0]  r_acc_hi;
  logic [OPW-1:0]  r_q;
  logic [CNTW-1:0] r_cnt;
  logic [PW-1:0]   r_product;

  logic [OPW-1:0]  w_addend;
  logic [OPW-1:0]  w_sum;
  logic            w_cout;
  logic [PW-1:0]   w_step;
  logic            w_last;

  assign w_addend = r_q[0] ? r_mcand : '0;
  assign w_step   = {w_cout, w_sum, r_q[OPW-1:1]};
  assign w_last   = (r_cnt == CNTW'(MUL_STEPS - 1));

  rca4 u_add (
    .i_a    (r_acc_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: if (io_bus.start) w_state_d = ST_RUN;
      ST_RUN:  if (w_last) w_state_d = ST_DONE;
      ST_DONE: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.start) begin
            r_mcand  <= io_bus.a;
            r_q      <= io_bus.b;
            r_acc_hi <= '0;
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          {r_acc_hi, r_q} <= w_step;
          r_cnt           <= r_cnt + 1'b1;
          if (w_last) r_product <= w_step;
        end
        ST_DONE: begin
          if (!HOLD_PRODUCT) r_product <= '0;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.busy    = (r_state != ST_IDLE);
  assign io_bus.done    = (r_state == ST_DONE);
  assign io_bus.product = r_product;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Directed self-checking bench: one HOLD_PRODUCT=1 and one HOLD_PRODUCT=0 instance
// driven with identical stimulus.
module tb_mul4_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mul4_seq_ctrl_if bus ();
  mul4_seq_ctrl_if bus0 ();

  assign bus0.start = bus.start;
  assign bus0.a     = bus.a;
  assign bus0.b     = bus.b;

  mul4_seq_ctrl #(.HOLD_PRODUCT(1'b1)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  mul4_seq_ctrl #(.HOLD_PRODUCT(1'b0)) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept at edge N, done expected after edge N+4, idle after N+5.
  task automatic do_mul(input logic [3:0] ia, input logic [3:0] ib, input logic [7:0] exp,
                        input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = ~ia;
    bus.b     = ~ib;
    check({tag, ".busy_after_accept"}, 32'(bus.busy), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check({tag, ".done_early"}, 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".product"}, 32'(bus.product), 32'(exp));
    check({tag, ".product_nohold"}, 32'(bus0.product), 32'(exp));
    @(posedge clk); #1;
    check({tag, ".done_low"}, 32'(bus.done), 32'd0);
    check({tag, ".idle"}, 32'(bus.busy), 32'd0);
    check({tag, ".product_held"}, 32'(bus.product), 32'(exp));
    check({tag, ".product_cleared"}, 32'(bus0.product), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.a     = 4'h0;
    bus.b     = 4'h0;
    rst_n     = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.product", 32'(bus.product), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.stay_idle", 32'(bus.busy), 32'd0);

    // Directed products
    do_mul(4'd15, 4'd15, 8'hE1, "m15x15");
    do_mul(4'd9,  4'd6,  8'h36, "m9x6");
    do_mul(4'd0,  4'd13, 8'h00, "m0x13");
    do_mul(4'd7,  4'd1,  8'h07, "m7x1");

    // Exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        do_mul(4'(i), 4'(j), 8'(i * j), "sweep");
      end
    end

    // Start during RUN and DONE is dropped
    begin
      int n_done;
      n_done = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd3;
      bus.b     = 4'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.a     = 4'd15;
      bus.b     = 4'd15;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (bus.done) begin
          n_done++;
          check("busy_req.product", 32'(bus.product), 32'h0F);
        end
        if (k == 3) bus.start = 1'b0;
      end
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (bus.done) n_done++;
      end
      check("busy_req.done_count", 32'(n_done), 32'd1);
      check("busy_req.idle", 32'(bus.busy), 32'd0);
      check("busy_req.product_kept", 32'(bus.product), 32'h0F);
    end

    // Reset mid-operation
    begin
      int n_done;
      n_done = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd12;
      bus.b     = 4'd11;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst.busy", 32'(bus.busy), 32'd0);
      check("midrst.done", 32'(bus.done), 32'd0);
      check("midrst.product", 32'(bus.product), 32'h00);
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (bus.done) n_done++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (bus.done) n_done++;
      end
      check("midrst.no_done", 32'(n_done), 32'd0);
      do_mul(4'd2, 4'd3, 8'h06, "after_rst");
    end

    // Back-to-back with start held high
    begin
      int last_done;
      int n_done;
      logic prev_done;
      last_done = -1;
      n_done    = 0;
      prev_done = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd5;
      bus.b     = 4'd6;
      for (int cyc = 0; cyc < 36; cyc++) begin
        @(posedge clk); #1;
        if (bus.done) begin
          if (last_done >= 0) check("b2b.period", 32'(cyc - last_done), 32'd6);
          last_done = cyc;
          n_done++;
          check("b2b.product", 32'(bus.product), 32'd30);
          check("b2b.product_nohold", 32'(bus0.product), 32'd30);
        end else if (prev_done) begin
          check("b2b.product_held", 32'(bus.product), 32'd30);
          check("b2b.product_cleared", 32'(bus0.product), 32'd0);
        end
        prev_done = bus.done;
      end
      check("b2b.done_count", 32'(n_done), 32'd6);
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("b2b.idle", 32'(bus.busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
